// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, BCD digit type and playfield geometry
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int TUBE_WIDTH    = 120;
    localparam int GAP_HEIGHT    = 400;
    localparam int SCREEN_HEIGHT = 768;

endpackage

// File: rtl/game_fsm_score_bcd.sv
// rtl/game_fsm_score_bcd.sv - 4-digit BCD counter with clear and saturation at 9999
module bcd_counter4
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] value
);

    logic [15:0] value_inc;
    logic        carry;
    bcd_digit_t  dig;

    // Ripple a +1 through the digits; a digit at 9 wraps to 0 and passes the carry on.
    always_comb begin
        value_inc = value;
        carry     = 1'b1;
        dig       = '0;
        for (int i = 0; i < 4; i++) begin
            dig = value[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    value_inc[4*i +: 4] = 4'd0;
                end else begin
                    value_inc[4*i +: 4] = dig + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && value != 16'h9999) begin
            value <= value_inc;
        end
    end

endmodule

// File: rtl/game_fsm_score.sv
// rtl/game_fsm_score.sv - game state machine with collision detection and BCD scoring
module game_fsm_score
    import game_pkg::*;
#(
    parameter int BIRD_X        = 200,
    parameter int BIRD_SIZE     = 32,
    parameter int TUBE_WIDTH    = game_pkg::TUBE_WIDTH,
    parameter int GAP_HEIGHT    = game_pkg::GAP_HEIGHT,
    parameter int SCREEN_HEIGHT = game_pkg::SCREEN_HEIGHT,
    parameter int DEAD_HOLD     = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flap,
    input  logic [10:0] bird_y,
    input  logic [10:0] tube_x [2:0],
    input  logic [10:0] gap_y  [2:0],
    output logic        game_rst,
    output state_t      state,
    output logic        hit,
    output logic [15:0] score,
    output logic [15:0] high_score
);

    localparam int CW = $clog2(DEAD_HOLD + 1);
    localparam logic [11:0] X_LO  = 12'(BIRD_X);
    localparam logic [11:0] X_HI  = 12'(BIRD_X + BIRD_SIZE + TUBE_WIDTH);
    localparam logic [11:0] SZ    = 12'(BIRD_SIZE);
    localparam logic [11:0] GAP   = 12'(GAP_HEIGHT);
    localparam logic [11:0] FLOOR = 12'(SCREEN_HEIGHT);

    state_t        state_n;
    logic          hit_n, flap_q, flap_evt, collide, sc_inc, sc_clr;
    logic [2:0]    passed_q, passed_now, rise, pend, pend_n, lowest;
    logic [CW-1:0] dead_cnt, cnt_n;
    logic [15:0]   hs_n;
    logic [11:0]   by, bot, tx, gy;

    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic gt, decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && a[4*i +: 4] != b[4*i +: 4]) begin
                gt      = a[4*i +: 4] > b[4*i +: 4];
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

    assign flap_evt = flap & ~flap_q;
    assign by       = {1'b0, bird_y};
    assign bot      = by + SZ;
    assign rise     = passed_now & ~passed_q;
    assign lowest   = pend & (~pend + 3'd1);

    // 12-bit geometry so tube_x near zero cannot wrap the window compare.
    always_comb begin
        collide    = (bot >= FLOOR);
        passed_now = '0;
        tx         = '0;
        gy         = '0;
        for (int i = 0; i < 3; i++) begin
            tx = {1'b0, tube_x[i]};
            gy = {1'b0, gap_y[i]};
            if (tx > X_LO && tx < X_HI && (by < gy || bot > gy + GAP))
                collide = 1'b1;
            passed_now[i] = (tx <= X_LO);
        end
    end

    always_comb begin
        state_n = state;
        hit_n   = 1'b0;
        pend_n  = pend;
        cnt_n   = dead_cnt;
        hs_n    = high_score;
        sc_inc  = 1'b0;
        sc_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (flap_evt) begin
                    state_n = PLAY;
                    pend_n  = '0;
                    sc_clr  = 1'b1;
                end
            end
            PLAY: begin
                // A collision discards any passes still waiting to be scored.
                if (collide) begin
                    state_n = DEAD;
                    hit_n   = 1'b1;
                    pend_n  = '0;
                    cnt_n   = CW'(DEAD_HOLD - 1);
                    if (bcd_gt(score, high_score))
                        hs_n = score;
                end else begin
                    sc_inc = |pend;
                    pend_n = (pend & ~lowest) | rise;
                end
            end
            DEAD: begin
                if (dead_cnt != '0)
                    cnt_n = dead_cnt - 1'b1;
                else if (flap_evt)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            game_rst   <= 1'b1;
            hit        <= 1'b0;
            high_score <= '0;
            pend       <= '0;
            passed_q   <= 3'b111;
            flap_q     <= 1'b0;
            dead_cnt   <= '0;
        end else begin
            state      <= state_n;
            game_rst   <= (state_n == IDLE);
            hit        <= hit_n;
            high_score <= hs_n;
            pend       <= pend_n;
            passed_q   <= passed_now;
            flap_q     <= flap;
            dead_cnt   <= cnt_n;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst   (rst),
        .inc   (sc_inc),
        .clr   (sc_clr),
        .value (score)
    );

endmodule

// File: tb/tb_game_fsm_score.sv
// tb/tb_game_fsm_score.sv - scoreboard bench for game_fsm_score
module tb_game_fsm_score;
    import game_pkg::*;

    localparam int K_STATE = 0;
    localparam int K_HIT   = 1;
    localparam int K_SCORE = 2;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } ev_t;

    logic        clk, rst, flap;
    logic [10:0] bird_y;
    logic [10:0] tube_x [2:0];
    logic [10:0] gap_y  [2:0];
    logic        game_rst, hit;
    state_t      state;
    logic [15:0] score, high_score;

    ev_t         exp_q [$];
    int          tests, fails;
    logic [15:0] exp_score;

    game_fsm_score #(.DEAD_HOLD(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .flap       (flap),
        .bird_y     (bird_y),
        .tube_x     (tube_x),
        .gap_y      (gap_y),
        .game_rst   (game_rst),
        .state      (state),
        .hit        (hit),
        .score      (score),
        .high_score (high_score)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        int n;
        n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
        if (n < 9999) n++;
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // One tube crosses the bird line and leaves again: exactly one pass.
    task automatic pass_tube(input int i);
        logic [15:0] nxt;
        nxt = bcd_inc(exp_score);
        if (nxt != exp_score) push(K_SCORE, nxt);
        exp_score = nxt;
        tube_x[i] = 11'd100;
        step(1);
        tube_x[i] = 11'd1000;
        step(1);
    endtask

    task automatic observe(input int kind, input logic [15:0] val);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d value 0x%04h expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                fails++;
                $display("FAIL event: got kind %0d value 0x%04h expected kind %0d value 0x%04h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    initial begin
        state_t      prev_state;
        logic [15:0] prev_score;
        prev_state = IDLE;
        prev_score = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_state = state;
                prev_score = score;
            end else begin
                if (state != prev_state) observe(K_STATE, {14'b0, state});
                if (hit) observe(K_HIT, 16'd1);
                if (score != prev_score) observe(K_SCORE, score);
                prev_state = state;
                prev_score = score;
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        exp_score = '0;
        rst = 1'b1;
        flap = 1'b0;
        bird_y = 11'd200;
        for (int i = 0; i < 3; i++) begin
            tube_x[i] = 11'd1000;
            gap_y[i]  = 11'd100;
        end
        step(3);
        rst = 1'b0;
        step(1);
        chk("reset_state", {14'b0, state}, 16'(IDLE));
        chk("reset_game_rst", {15'b0, game_rst}, 16'd1);
        chk("reset_score", score, 16'h0000);
        chk("reset_high", high_score, 16'h0000);
        for (int c = 0; c < 100; c++) begin
            chk("idle_no_hit", {15'b0, hit}, 16'd0);
            step(1);
        end

        push(K_STATE, 16'(PLAY));
        flap = 1'b1;
        step(1);
        chk("flap_play", {14'b0, state}, 16'(PLAY));
        chk("play_game_rst", {15'b0, game_rst}, 16'd0);
        step(5);
        chk("flap_held", {14'b0, state}, 16'(PLAY));
        flap = 1'b0;

        tube_x[0] = 11'd300;
        step(4);
        chk("in_gap_no_hit", {15'b0, hit}, 16'd0);
        tube_x[0] = 11'd1000;

        tube_x[1] = 11'd202;
        step(1);
        tube_x[1] = 11'd201;
        step(1);
        exp_score = 16'h0001;
        push(K_SCORE, exp_score);
        tube_x[1] = 11'd200;
        step(1);
        chk("score_one_cycle", score, 16'h0000);
        step(1);
        chk("score_two_cycles", score, 16'h0001);
        tube_x[1] = 11'd1000;
        step(2);
        chk("wrap_no_score", score, 16'h0001);

        push(K_SCORE, 16'h0002);
        push(K_SCORE, 16'h0003);
        exp_score = 16'h0003;
        tube_x[0] = 11'd150;
        tube_x[2] = 11'd150;
        step(4);
        chk("dual_pass", score, 16'h0003);
        tube_x[0] = 11'd1000;
        tube_x[2] = 11'd1000;
        step(1);

        while (exp_score != 16'h9999) begin
            pass_tube(0);
            if (exp_score == 16'h0010) chk("carry_0010", score, 16'h0010);
            if (exp_score == 16'h0100) chk("carry_0100", score, 16'h0100);
        end
        chk("reach_9999", score, 16'h9999);
        pass_tube(0);
        chk("saturate_9999", score, 16'h9999);

        tube_x[0] = 11'd300;
        step(3);
        chk("no_hit_before", {15'b0, hit}, 16'd0);
        push(K_STATE, 16'(DEAD));
        push(K_HIT, 16'd1);
        bird_y = 11'd480;
        step(1);
        chk("hit_pulse", {15'b0, hit}, 16'd1);
        chk("dead_state", {14'b0, state}, 16'(DEAD));
        chk("high_updated", high_score, 16'h9999);
        step(1);
        chk("hit_one_cycle", {15'b0, hit}, 16'd0);
        step(2);
        flap = 1'b1;
        step(1);
        flap = 1'b0;
        chk("dead_flap_ignored", {14'b0, state}, 16'(DEAD));
        step(6);
        chk("dead_before_timeout", {14'b0, state}, 16'(DEAD));
        push(K_STATE, 16'(IDLE));
        flap = 1'b1;
        step(1);
        flap = 1'b0;
        chk("dead_to_idle", {14'b0, state}, 16'(IDLE));
        chk("idle_game_rst", {15'b0, game_rst}, 16'd1);

        bird_y = 11'd200;
        step(2);
        exp_score = 16'h0000;
        push(K_STATE, 16'(PLAY));
        push(K_SCORE, 16'h0000);
        flap = 1'b1;
        step(1);
        flap = 1'b0;
        chk("restart_clear", score, 16'h0000);
        pass_tube(2);
        chk("second_game_pass", score, 16'h0001);
        tube_x[1] = 11'd100;
        step(1);
        push(K_STATE, 16'(DEAD));
        push(K_HIT, 16'd1);
        bird_y = 11'd480;
        step(3);
        chk("hit_beats_pass", score, 16'h0001);
        chk("high_kept", high_score, 16'h9999);

        rst = 1'b1;
        #1;
        chk("async_rst_state", {14'b0, state}, 16'(IDLE));
        chk("async_rst_high", high_score, 16'h0000);
        chk("async_rst_score", score, 16'h0000);
        for (int i = 0; i < 3; i++) tube_x[i] = 11'd1000;
        bird_y = 11'd200;
        step(1);
        rst = 1'b0;
        step(2);

        push(K_STATE, 16'(PLAY));
        flap = 1'b1;
        step(1);
        flap = 1'b0;
        bird_y = 11'd600;
        tube_x[0] = 11'd352;
        step(3);
        chk("overlap_edge", {14'b0, state}, 16'(PLAY));
        tube_x[0] = 11'd1000;
        bird_y = 11'd735;
        step(3);
        chk("floor_minus1", {14'b0, state}, 16'(PLAY));
        push(K_STATE, 16'(DEAD));
        push(K_HIT, 16'd1);
        bird_y = 11'd736;
        step(2);
        chk("floor_hit", {14'b0, state}, 16'(DEAD));

        step(3);
        chk("events_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_fsm_score.md
GAME_FSM_SCORE -- requirements
Module: game_fsm_score

Interface
REQ-001 The block SHALL be clocked by clk, and reset rst SHALL be asynchronous and active-high.
REQ-002 Parameters (name, default, meaning):
  BIRD_X, 200, bird left edge in pixels.
  BIRD_SIZE, 32, bird square side in pixels.
  TUBE_WIDTH, 120, tube width in pixels.
  GAP_HEIGHT, 400, vertical gap height.
  SCREEN_HEIGHT, 768, floor y coordinate.
  DEAD_HOLD, 50_000_000, DEAD lockout in cycles.
REQ-003 Ports (name, direction, width, meaning):
  clk  in  1  clock.
  rst  in  1  async active-high reset.
  flap  in  1  debounced button level, synchronous to clk.
  bird_y  in  11  bird top edge.
  tube_x[2:0]  in  11 each  tube right edge; the tube occupies [tube_x-TUBE_WIDTH, tube_x).
  gap_y[2:0]  in  11 each  gap top; the gap occupies [gap_y, gap_y+GAP_HEIGHT).
  game_rst  out  1  hold tube/bird producers in their start state.
  state  out  2  current game state (package enum).
  hit  out  1  one-cycle collision pulse.
  score  out  16  4-digit BCD current score.
  high_score  out  16  4-digit BCD best score.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, PLAY and DEAD.
REQ-005 flap SHALL be edge-detected internally, and only a 0->1 transition SHALL count as a flap event.
REQ-006 In IDLE, game_rst SHALL be 1, and a flap event SHALL move the FSM to PLAY on the next edge.
REQ-007 The transition IDLE->PLAY SHALL clear score and all pending-pass bits.
REQ-008 In PLAY and DEAD, game_rst SHALL be 0.
REQ-009 In DEAD, the tubes freeze because the tube producer's tick is gated externally by state.
REQ-010 A tube i SHALL horizontally overlap the bird iff BIRD_X < tube_x[i] < BIRD_X+BIRD_SIZE+TUBE_WIDTH.
REQ-011 The overlap comparison SHALL be evaluated at 12-bit width so that no underflow occurs.
REQ-012 An overlapping tube i SHALL cause a collision iff bird_y < gap_y[i] or bird_y+BIRD_SIZE > gap_y[i]+GAP_HEIGHT.
REQ-013 A floor collision SHALL occur iff bird_y+BIRD_SIZE >= SCREEN_HEIGHT.
REQ-014 A collision in PLAY SHALL assert hit for exactly one cycle on the next edge.
REQ-015 The same edge as the hit pulse SHALL move the FSM to DEAD and load the DEAD counter with DEAD_HOLD-1.
REQ-016 Collisions SHALL be ignored in IDLE and DEAD.
REQ-017 Pass detection: passed[i] = (tube_x[i] <= BIRD_X), registered each cycle.
REQ-018 A 0->1 transition of passed[i] in PLAY SHALL set pend[i].
REQ-019 A 1->0 transition of passed[i] (tube wrap) SHALL NOT score.
REQ-020 Each cycle in PLAY, the lowest set pend bit SHALL be cleared and score incremented by exactly 1 (BCD).
REQ-021 Simultaneous passes SHALL be serialized, with at most one increment per cycle.
REQ-022 When a collision and a score increment occur in the same cycle, hit SHALL win: no increment, and pend SHALL be cleared.
REQ-023 BCD increment SHALL carry per digit (0009->0010, 0099->0100).
REQ-024 The score SHALL saturate at 9999.
REQ-025 In DEAD, the counter SHALL decrement to 0, and flap events SHALL be ignored while it is nonzero.
REQ-026 A flap event in DEAD with the counter at 0 SHALL move the FSM to IDLE.
REQ-027 On entry to DEAD, high_score SHALL be updated to score if score > high_score (BCD compare, digit-wise MSB first).
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Reset SHALL force state=IDLE, game_rst=1, hit=0, score=0, high_score=0, pend=0 and passed=3'b111 (no false pass after release), with the edge detector and DEAD counter at 0.
REQ-030 Reset asserted mid-game SHALL abort immediately and discard high_score.

Structure
REQ-031 Package game_pkg SHALL hold the state enum (IDLE=0, PLAY=1, DEAD=2), the BCD digit typedef and the shared geometry constants (TUBE_WIDTH, GAP_HEIGHT, SCREEN_HEIGHT).
REQ-032 Sub-module bcd_counter4 SHALL implement the saturating 4-digit increment/clear (inputs inc and clr; output value).
REQ-033 The high_score comparison SHALL reside in the top level.

Verification
REQ-034 Reset, then release: state=IDLE, game_rst=1, score=0x0000, and hit stays 0 for 100 cycles.
REQ-035 flap rising in IDLE: state=PLAY and game_rst=0 one cycle later; holding flap high produces no further events.
REQ-036 PLAY with tube_x[0]=300, gap_y[0]=100: bird_y=200 gives hit=0; bird_y=480 gives a single-cycle hit=1 and state=DEAD one cycle later.
REQ-037 bird in gap with tube_x[1] stepping 202->200: score=0x0001 two cycles after tube_x reaches 200; a same-cycle pass of tubes 0 and 2 yields +1 per cycle, ending +2.
REQ-038 Preload score 0x0009 then pass: 0x0010; at 0x9999 a pass keeps 0x9999.
REQ-039 DEAD with DEAD_HOLD=10: a flap at cycle 5 is ignored; a flap at cycle 12 gives IDLE; high_score equals the final score.
